// File: rtl/alu_pkg.sv
// Shared opcode encodings, tag layout and legality check for the ALU and its arbiter.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;
  localparam logic [3:0] OP_SHL = 4'b1101;
  localparam logic [3:0] OP_ROR = 4'b1110;
  localparam logic [3:0] OP_ROL = 4'b1111;

  // Register stages inside alu from its inputs to O.
  localparam int ALU_LAT_DEFAULT = 2;

  // Per-operation bookkeeping carried alongside the ALU pipeline.
  typedef struct packed {
    logic valid;
    logic port;
    logic illegal;
  } tag_t;

  // Legal opcodes are 0000, 0001 and the whole 1xxx range.
  function automatic logic is_legal_op(input logic [3:0] op);
    if (op[3] == 1'b1) begin
      return 1'b1;
    end else if (op[2:1] == 2'b00) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/alu.sv
// 8-bit ALU with registered inputs and LAT-1 registered result stages (LAT >= 2).
// No reset: outputs are only meaningful when the caller's tag says so.
module alu
  import alu_pkg::*;
#(
  parameter int LAT = ALU_LAT_DEFAULT
) (
  input  logic       ck,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] CTR,
  output logic [7:0] O
);

  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [3:0] ctr_r;
  logic [7:0] res_s;
  logic [7:0] pipe_r [LAT-1];

  // Input register stage.
  always_ff @(posedge ck) begin
    a_r   <= A;
    b_r   <= B;
    ctr_r <= CTR;
  end

  // Operation decode; illegal opcodes yield zero.
  always_comb begin
    res_s = 8'h00;
    case (ctr_r)
      OP_ADD:  res_s = a_r + b_r;
      OP_SUB:  res_s = a_r - b_r;
      OP_AND:  res_s = a_r & b_r;
      OP_OR:   res_s = a_r | b_r;
      OP_XOR:  res_s = a_r ^ b_r;
      OP_NOT:  res_s = ~a_r;
      OP_SHR:  res_s = {1'b0, a_r[7:1]};
      OP_SHL:  res_s = {a_r[6:0], 1'b0};
      OP_ROR:  res_s = {a_r[0], a_r[7:1]};
      OP_ROL:  res_s = {a_r[6:0], a_r[7]};
      default: res_s = 8'h00;
    endcase
  end

  // Result delay stages so O lands LAT edges after the inputs.
  always_ff @(posedge ck) begin
    pipe_r[0] <= res_s;
    for (int k = 1; k < LAT - 1; k++) begin
      pipe_r[k] <= pipe_r[k-1];
    end
  end

  assign O = pipe_r[LAT-2];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu between two requesters, with a tag pipeline
// that steers each result back to its issuer after a fixed latency.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEFAULT
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic [3:0] ctr0,
  input  logic [3:0] ctr1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rsp_valid0,
  output logic       rsp_valid1,
  output logic       rsp_err,
  output logic [7:0] rsp_data,
  output logic       busy
);

  logic       last_r;
  logic       gnt0_s;
  logic       gnt1_s;
  logic [7:0] nxt_a_s;
  logic [7:0] nxt_b_s;
  logic [3:0] nxt_ctr_s;
  tag_t       nxt_tag_s;
  logic [7:0] issue_a_r;
  logic [7:0] issue_b_r;
  logic [3:0] issue_ctr_r;
  tag_t       tag_r [ALU_LAT+1];
  logic [7:0] alu_o_s;
  logic       busy_s;

  // Grant: single requester wins outright; on conflict the port that did not go last wins.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0 && req1) begin
      gnt0_s = last_r;
      gnt1_s = ~last_r;
    end else begin
      gnt0_s = req0;
      gnt1_s = req1;
    end
  end

  // Remember which port was granted most recently; reset favours port 0.
  always_ff @(posedge ck) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (gnt0_s) begin
      last_r <= 1'b0;
    end else if (gnt1_s) begin
      last_r <= 1'b1;
    end
  end

  // Select the granted operands and tag, or a NOP when nothing is accepted.
  always_comb begin
    nxt_a_s           = 8'h00;
    nxt_b_s           = 8'h00;
    nxt_ctr_s         = 4'b0000;
    nxt_tag_s.valid   = 1'b0;
    nxt_tag_s.port    = 1'b0;
    nxt_tag_s.illegal = 1'b0;
    if (gnt0_s) begin
      nxt_a_s           = a0;
      nxt_b_s           = b0;
      nxt_ctr_s         = ctr0;
      nxt_tag_s.valid   = 1'b1;
      nxt_tag_s.port    = 1'b0;
      nxt_tag_s.illegal = ~is_legal_op(ctr0);
    end else if (gnt1_s) begin
      nxt_a_s           = a1;
      nxt_b_s           = b1;
      nxt_ctr_s         = ctr1;
      nxt_tag_s.valid   = 1'b1;
      nxt_tag_s.port    = 1'b1;
      nxt_tag_s.illegal = ~is_legal_op(ctr1);
    end else begin
      nxt_a_s   = 8'h00;
      nxt_b_s   = 8'h00;
      nxt_ctr_s = 4'b0000;
    end
  end

  // Issue register feeding the alu inputs.
  always_ff @(posedge ck) begin
    if (rst) begin
      issue_a_r   <= 8'h00;
      issue_b_r   <= 8'h00;
      issue_ctr_r <= 4'b0000;
    end else begin
      issue_a_r   <= nxt_a_s;
      issue_b_r   <= nxt_b_s;
      issue_ctr_r <= nxt_ctr_s;
    end
  end

  // Tag pipeline: stage 0 parallels the issue register, last stage lines up with alu O.
  always_ff @(posedge ck) begin
    if (rst) begin
      for (int k = 0; k <= ALU_LAT; k++) begin
        tag_r[k] <= '{valid: 1'b0, port: 1'b0, illegal: 1'b0};
      end
    end else begin
      tag_r[0] <= nxt_tag_s;
      for (int k = 1; k <= ALU_LAT; k++) begin
        tag_r[k] <= tag_r[k-1];
      end
    end
  end

  alu #(
    .LAT (ALU_LAT)
  ) u_alu (
    .ck  (ck),
    .A   (issue_a_r),
    .B   (issue_b_r),
    .CTR (issue_ctr_r),
    .O   (alu_o_s)
  );

  // Any valid tag anywhere in the pipeline means work is in flight.
  always_comb begin
    busy_s = 1'b0;
    for (int k = 0; k <= ALU_LAT; k++) begin
      busy_s = busy_s | tag_r[k].valid;
    end
  end

  assign gnt0       = gnt0_s;
  assign gnt1       = gnt1_s;
  assign rsp_valid0 = tag_r[ALU_LAT].valid & ~tag_r[ALU_LAT].port;
  assign rsp_valid1 = tag_r[ALU_LAT].valid & tag_r[ALU_LAT].port;
  assign rsp_err    = tag_r[ALU_LAT].valid & tag_r[ALU_LAT].illegal;
  assign rsp_data   = alu_o_s;
  assign busy       = busy_s;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter: inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       ck;
  logic       rst;
  logic       req0;
  logic       req1;
  logic [7:0] a0;
  logic [7:0] b0;
  logic [7:0] a1;
  logic [7:0] b1;
  logic [3:0] ctr0;
  logic [3:0] ctr1;
  logic       gnt0;
  logic       gnt1;
  logic       rsp_valid0;
  logic       rsp_valid1;
  logic       rsp_err;
  logic [7:0] rsp_data;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Back-to-back port 0 vectors with hand-computed results.
  localparam int NV = 9;
  localparam logic [3:0] VC [NV] = '{OP_ADD, OP_ROR, OP_ROL, OP_SHL, OP_SHR, OP_NOT, OP_XOR, OP_OR, OP_SUB};
  localparam logic [7:0] VA [NV] = '{8'hFF, 8'h01, 8'h80, 8'h81, 8'h81, 8'h0F, 8'hAA, 8'h12, 8'h10};
  localparam logic [7:0] VB [NV] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h21, 8'h01};
  localparam logic [7:0] VR [NV] = '{8'h00, 8'h80, 8'h01, 8'h02, 8'h40, 8'hF0, 8'h55, 8'h33, 8'h0F};

  alu_arbiter dut (
    .ck(ck), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ctr0(ctr0), .ctr1(ctr1),
    .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_err(rsp_err), .rsp_data(rsp_data), .busy(busy)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    @(negedge ck);
    total_cnt++; if (gnt0 !== 1'b0) $display("FAIL reset_gnt0: got %b expected 0", gnt0); else pass_cnt++;
    total_cnt++; if (gnt1 !== 1'b0) $display("FAIL reset_gnt1: got %b expected 0", gnt1); else pass_cnt++;
    tick();
    tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge ck);
    total_cnt++; if (rsp_valid0 !== 1'b0) $display("FAIL reset_valid0: got %b expected 0", rsp_valid0); else pass_cnt++;
    total_cnt++; if (rsp_valid1 !== 1'b0) $display("FAIL reset_valid1: got %b expected 0", rsp_valid1); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", rsp_err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    tick();
  endtask

  task automatic test_single();
    req0 = 1'b1; a0 = 8'h05; b0 = 8'h03; ctr0 = OP_ADD;
    @(negedge ck);
    total_cnt++; if (gnt0 !== 1'b1) $display("FAIL single_gnt0: got %b expected 1", gnt0); else pass_cnt++;
    total_cnt++; if (gnt1 !== 1'b0) $display("FAIL single_gnt1: got %b expected 0", gnt1); else pass_cnt++;
    tick();
    req0 = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge ck);
      total_cnt++; if (rsp_valid0 !== 1'b0) $display("FAIL single_early_strobe: cycle %0d got %b expected 0", c, rsp_valid0); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: cycle %0d got %b expected 1", c, busy); else pass_cnt++;
      tick();
    end
    @(negedge ck);
    total_cnt++; if (rsp_valid0 !== 1'b1) $display("FAIL single_valid0: got %b expected 1", rsp_valid0); else pass_cnt++;
    total_cnt++; if (rsp_data !== 8'h08) $display("FAIL single_data: got %h expected 08", rsp_data); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b0) $display("FAIL single_err: got %b expected 0", rsp_err); else pass_cnt++;
    total_cnt++; if (rsp_valid1 !== 1'b0) $display("FAIL single_valid1: got %b expected 0", rsp_valid1); else pass_cnt++;
    tick();
    @(negedge ck);
    total_cnt++; if (rsp_valid0 !== 1'b0) $display("FAIL single_strobe_len: got %b expected 0", rsp_valid0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b expected 0", busy); else pass_cnt++;
    tick();
  endtask

  task automatic test_conflict();
    logic exp_port;
    do_reset();
    a0 = 8'hF0; b0 = 8'h3C; ctr0 = OP_AND;
    a1 = 8'h01; b1 = 8'h02; ctr1 = OP_SUB;
    for (int c = 0; c < 7; c++) begin
      req0 = (c < 4); req1 = (c < 4);
      @(negedge ck);
      if (c < 4) begin
        exp_port = c[0];
        total_cnt++; if (gnt0 !== ~exp_port) $display("FAIL conflict_gnt0: cycle %0d got %b expected %b", c, gnt0, ~exp_port); else pass_cnt++;
        total_cnt++; if (gnt1 !== exp_port) $display("FAIL conflict_gnt1: cycle %0d got %b expected %b", c, gnt1, exp_port); else pass_cnt++;
      end
      if (c >= 3) begin
        exp_port = c[0] ^ 1'b1;
        total_cnt++; if (rsp_valid0 !== ~exp_port) $display("FAIL conflict_valid0: cycle %0d got %b expected %b", c, rsp_valid0, ~exp_port); else pass_cnt++;
        total_cnt++; if (rsp_valid1 !== exp_port) $display("FAIL conflict_valid1: cycle %0d got %b expected %b", c, rsp_valid1, exp_port); else pass_cnt++;
        total_cnt++; if (rsp_data !== (exp_port ? 8'hFF : 8'h30)) $display("FAIL conflict_data: cycle %0d got %h expected %h", c, rsp_data, (exp_port ? 8'hFF : 8'h30)); else pass_cnt++;
      end
      tick();
    end
    // Last grant went to port 1, so the next conflict belongs to port 0.
    req0 = 1'b1; req1 = 1'b1;
    @(negedge ck);
    total_cnt++; if (gnt0 !== 1'b1) $display("FAIL conflict_next_gnt0: got %b expected 1", gnt0); else pass_cnt++;
    total_cnt++; if (gnt1 !== 1'b0) $display("FAIL conflict_next_gnt1: got %b expected 0", gnt1); else pass_cnt++;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < NV + 3; c++) begin
      if (c < NV) begin
        req0 = 1'b1; a0 = VA[c]; b0 = VB[c]; ctr0 = VC[c];
      end else begin
        req0 = 1'b0;
      end
      @(negedge ck);
      if (c < NV) begin
        total_cnt++; if (gnt0 !== 1'b1) $display("FAIL b2b_gnt0: cycle %0d got %b expected 1", c, gnt0); else pass_cnt++;
      end
      if (c >= 3) begin
        total_cnt++; if (rsp_valid0 !== 1'b1) $display("FAIL b2b_valid0: cycle %0d got %b expected 1", c, rsp_valid0); else pass_cnt++;
        total_cnt++; if (rsp_data !== VR[c-3]) $display("FAIL b2b_data: vector %0d got %h expected %h", c - 3, rsp_data, VR[c-3]); else pass_cnt++;
        total_cnt++; if (rsp_err !== 1'b0) $display("FAIL b2b_err: vector %0d got %b expected 0", c - 3, rsp_err); else pass_cnt++;
      end
      tick();
    end
    @(negedge ck);
    total_cnt++; if (rsp_valid0 !== 1'b0) $display("FAIL b2b_tail: got %b expected 0", rsp_valid0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_busy: got %b expected 0", busy); else pass_cnt++;
    tick();
  endtask

  task automatic test_illegal();
    req1 = 1'b1; a1 = 8'h12; b1 = 8'h34; ctr1 = 4'b0101;
    @(negedge ck);
    total_cnt++; if (gnt1 !== 1'b1) $display("FAIL illegal_gnt1: got %b expected 1", gnt1); else pass_cnt++;
    tick();
    ctr1 = OP_ADD;
    @(negedge ck);
    total_cnt++; if (gnt1 !== 1'b1) $display("FAIL illegal_next_gnt1: got %b expected 1", gnt1); else pass_cnt++;
    tick();
    req1 = 1'b0;
    tick();
    @(negedge ck);
    total_cnt++; if (rsp_valid1 !== 1'b1) $display("FAIL illegal_valid1: got %b expected 1", rsp_valid1); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b1) $display("FAIL illegal_err: got %b expected 1", rsp_err); else pass_cnt++;
    total_cnt++; if (rsp_data !== 8'h00) $display("FAIL illegal_data: got %h expected 00", rsp_data); else pass_cnt++;
    total_cnt++; if (rsp_valid0 !== 1'b0) $display("FAIL illegal_valid0: got %b expected 0", rsp_valid0); else pass_cnt++;
    tick();
    @(negedge ck);
    total_cnt++; if (rsp_valid1 !== 1'b1) $display("FAIL legal_after_valid1: got %b expected 1", rsp_valid1); else pass_cnt++;
    total_cnt++; if (rsp_err !== 1'b0) $display("FAIL legal_after_err: got %b expected 0", rsp_err); else pass_cnt++;
    total_cnt++; if (rsp_data !== 8'h46) $display("FAIL legal_after_data: got %h expected 46", rsp_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req1 = 1'b1; a1 = 8'h01; b1 = 8'h01; ctr1 = OP_ADD;
    tick();
    req1 = 1'b0;
    req0 = 1'b1; a0 = 8'h02; b0 = 8'h02; ctr0 = OP_ADD;
    tick();
    // Port 0 went last; reset must restore port 0 priority anyway.
    rst = 1'b1;
    @(negedge ck);
    total_cnt++; if (gnt0 !== 1'b0) $display("FAIL midrst_gnt0_in_rst: got %b expected 0", gnt0); else pass_cnt++;
    tick();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    @(negedge ck);
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (gnt0 !== 1'b1) $display("FAIL midrst_conflict_gnt0: got %b expected 1", gnt0); else pass_cnt++;
    total_cnt++; if (gnt1 !== 1'b0) $display("FAIL midrst_conflict_gnt1: got %b expected 0", gnt1); else pass_cnt++;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge ck);
      total_cnt++; if (rsp_valid0 !== 1'b0) $display("FAIL midrst_valid0: cycle %0d got %b expected 0", c, rsp_valid0); else pass_cnt++;
      total_cnt++; if (rsp_valid1 !== 1'b0) $display("FAIL midrst_valid1: cycle %0d got %b expected 0", c, rsp_valid1); else pass_cnt++;
      tick();
    end
    @(negedge ck);
    total_cnt++; if (rsp_valid0 !== 1'b1) $display("FAIL midrst_new_valid0: got %b expected 1", rsp_valid0); else pass_cnt++;
    total_cnt++; if (rsp_data !== 8'h04) $display("FAIL midrst_new_data: got %h expected 04", rsp_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_idle();
    req0 = 1'b0; req1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge ck);
      total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: cycle %0d got %b expected 0", c, busy); else pass_cnt++;
      total_cnt++; if ((rsp_valid0 | rsp_valid1) !== 1'b0) $display("FAIL idle_strobe: cycle %0d got %b%b expected 00", c, rsp_valid0, rsp_valid1); else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    ctr0 = 4'b0000; ctr1 = 4'b0000;
    test_reset();
    test_single();
    test_conflict();
    test_back_to_back();
    test_illegal();
    test_reset_midflight();
    test_idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
